// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 storage: synchronous write, registered read,
// synchronous clear of every word and of the read register.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[index_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[index_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one serialised access per handshake with a
// fixed LATENCY. Optional macro DMEM_BOUNDS_CHECK_EN adds err_o address checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        stall_o
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        err_o
`endif
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               write_q;
  logic               ready_q;
  logic               valid_q;
  logic               rd_sel_q;
  logic               err_q;

  logic               accept;
  logic               go_resp;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic               acc_write;
  logic               acc_err;
  logic [31:0]        arr_rdata;

  assign accept  = (state_q == StIdle) && req_valid_i;
  assign go_resp = (accept && (LATENCY == 1)) || ((state_q == StBusy) && (cnt_q == '0));

  // With LATENCY=1 the array is accessed on the accept edge, before the latch is loaded.
  assign acc_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;
  assign acc_write = (state_q == StIdle) ? req_write_i : write_q;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr >= 32'(DEPTH_WORDS * WORD_BYTES));
  assign err_o   = err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};
  assign acc_err          = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .we_i    (go_resp && acc_write && !acc_err),
    .re_i    (go_resp && !acc_write && !acc_err),
    .index_i (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= go_resp;
      err_q   <= go_resp && acc_err;
      // Stores and faulting accesses present zero; the selection holds until the next response.
      if (go_resp) begin
        rd_sel_q <= !acc_write && !acc_err;
      end
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            write_q <= req_write_i;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= CNT_W'(LATENCY - 2);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rd_sel_q ? arr_rdata : '0;
  assign stall_o     = accept || (state_q == StBusy);

endmodule
